adder_seq: RTL and testbench

Multi-byte arithmetic sequencer wrapped around the 8-bit `adder` datapath. Accepts wide operands, feeds them through the adder one byte per clock from LSB to MSB, chains the carry/borrow between slices, assembles the wide result and produces C/Z/N/V flags. It sits between the operand registers and the result/flags write-back, so the CPU can run 16- and 32-bit add/sub on the single 8-bit adder.

---
 rtl/adder_seq_pkg.sv | 16 +
 rtl/adder_seq_adder.sv | 31 +++
 rtl/adder_seq.sv | 111 +++++++++++
 tb/tb_adder_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_seq_pkg.sv
// Shared encodings for the multi-byte add/sub sequencer: FSM states and
// bit positions inside the {C,Z,N,V} flags register.
package adder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/adder_seq_adder.sv
// 8-bit combinational add/sub slice. In subtract mode c_in/c_out/c6_out are
// borrows, so chaining slices works identically for both operations.
module adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  input  logic       sub,
  output logic [7:0] r,
  output logic       c_out,
  output logic       c6_out,
  output logic [7:0] xor_ab
);

  logic [7:0] bx;
  logic       cx;
  logic [7:0] lo;
  logic [1:0] hi;

  // a - b - borrow == a + ~b + ~borrow; carries invert back into borrows
  always_comb begin
    bx     = sub ? ~b : b;
    cx     = sub ? ~c_in : c_in;
    lo     = {1'b0, a[6:0]} + {1'b0, bx[6:0]} + {7'b0, cx};
    hi     = {1'b0, a[7]} + {1'b0, bx[7]} + {1'b0, lo[7]};
    r      = {hi[0], lo[6:0]};
    c6_out = lo[7] ^ sub;
    c_out  = hi[1] ^ sub;
    xor_ab = a ^ b;
  end

endmodule

// File: rtl/adder_seq.sv
// Runs BYTES-wide add/sub through one 8-bit adder, LSB byte first, chaining
// carry/borrow between slices and producing registered result and flags.
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [8*BYTES-1:0] op_a,
  input  logic [8*BYTES-1:0] op_b,
  input  logic               op_sub,
  input  logic               op_cin,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [8*BYTES-1:0] res,
  output logic               flag_c,
  output logic               flag_z,
  output logic               flag_n,
  output logic               flag_v
);

  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [BYTES-1:0][7:0]   a_q, b_q, res_q;
  logic                    sub_q;
  logic                    carry;
  logic                    z_acc;
  logic [3:0]              flags;

  logic [7:0] r;
  logic       c_out, c6_out;
  logic       accept;

  assign op_ready = (state == IDLE) | ((state == DONE) & res_ready);
  assign accept   = op_valid & op_ready;

  adder u_adder (
    .a      (a_q[idx]),
    .b      (b_q[idx]),
    .c_in   (carry),
    .sub    (sub_q),
    .r      (r),
    .c_out  (c_out),
    .c6_out (c6_out),
    .xor_ab ()
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      z_acc     <= 1'b0;
      res_q     <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
    end else if (accept) begin
      // accept only happens in IDLE or the DONE handshake, never mid-RUN
      a_q       <= op_a;
      b_q       <= op_b;
      sub_q     <= op_sub;
      carry     <= op_cin;
      idx       <= '0;
      z_acc     <= 1'b1;
      res_valid <= 1'b0;
      state     <= RUN;
    end else begin
      case (state)
        RUN: begin
          res_q[idx] <= r;
          carry      <= c_out;
          z_acc      <= z_acc & (r == 8'h00);
          if (idx == LAST) begin
            flags[FLAG_C] <= c_out;
            flags[FLAG_Z] <= z_acc & (r == 8'h00);
            flags[FLAG_N] <= r[7];
            flags[FLAG_V] <= c_out ^ c6_out;
            res_valid     <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign res    = res_q;
  assign flag_c = flags[FLAG_C];
  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];

endmodule

// File: tb/tb_adder_seq.sv
// Directed bench for adder_seq: a 4-byte instance for the main scenarios and
// a 1-byte instance for the single-slice case.
module tb_adder_seq;

  logic        clk, rst_n;
  logic        op_valid, op_ready, op_sub, op_cin, res_valid, res_ready;
  logic [31:0] op_a, op_b, res;
  logic        flag_c, flag_z, flag_n, flag_v;

  logic        op_valid1, op_ready1, op_sub1, op_cin1, res_valid1, res_ready1;
  logic [7:0]  op_a1, op_b1, res1;
  logic        flag_c1, flag_z1, flag_n1, flag_v1;

  int tests = 0;
  int fails = 0;

  adder_seq #(.BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .op_cin(op_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res(res),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  adder_seq #(.BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid1), .op_ready(op_ready1),
    .op_a(op_a1), .op_b(op_b1), .op_sub(op_sub1), .op_cin(op_cin1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res(res1),
    .flag_c(flag_c1), .flag_z(flag_z1), .flag_n(flag_n1), .flag_v(flag_v1)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Issues one op, scrambles inputs after acceptance, counts edges to res_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ci, output int lat);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = s; op_cin = ci; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0; op_a = ~a; op_b = ~b; op_sub = ~s; op_cin = ~ci;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_res();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #20;
    tests++; if (res !== 32'h0) begin fails++; $display("FAIL reset_res got=%h exp=0", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b0000) begin fails++;
      $display("FAIL reset_flags got=%b exp=0000", {flag_c, flag_z, flag_n, flag_v}); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", op_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL add_latency got=%0d exp=4", lat); end
    tests++; if (res !== 32'h0001_0000) begin fails++; $display("FAIL add_res got=%h exp=00010000", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b0000) begin fails++;
      $display("FAIL add_flags got=%b exp=0000", {flag_c, flag_z, flag_n, flag_v}); end
    take_res();
  endtask

  task automatic test_sub();
    int lat;
    run_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, lat);
    tests++; if (res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sub_borrow_res got=%h exp=ffffffff", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b1010) begin fails++;
      $display("FAIL sub_borrow_flags got=%b exp=1010", {flag_c, flag_z, flag_n, flag_v}); end
    take_res();
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, lat);
    tests++; if (res !== 32'h0) begin fails++; $display("FAIL sub_equal_res got=%h exp=0", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b0100) begin fails++;
      $display("FAIL sub_equal_flags got=%b exp=0100", {flag_c, flag_z, flag_n, flag_v}); end
    take_res();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    tests++; if (res !== 32'h8000_0000) begin fails++; $display("FAIL ovf_add_res got=%h exp=80000000", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b0011) begin fails++;
      $display("FAIL ovf_add_flags got=%b exp=0011", {flag_c, flag_z, flag_n, flag_v}); end
    take_res();
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, lat);
    tests++; if (res !== 32'h7FFF_FFFF) begin fails++; $display("FAIL ovf_sub_res got=%h exp=7fffffff", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b0001) begin fails++;
      $display("FAIL ovf_sub_flags got=%b exp=0001", {flag_c, flag_z, flag_n, flag_v}); end
    take_res();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    op_a = 32'h0101_0101; op_b = 32'h0101_0101; op_sub = 1'b0; op_cin = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #10 rst_n = 1'b0;
    #1;
    tests++; if (res !== 32'h0) begin fails++; $display("FAIL midrst_res got=%h exp=0", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b0000) begin fails++;
      $display("FAIL midrst_flags got=%b exp=0000", {flag_c, flag_z, flag_n, flag_v}); end
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", res_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", op_ready); end
    run_op(32'h1, 32'h1, 1'b0, 1'b0, lat);
    tests++; if (lat !== 4) begin fails++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
    tests++; if (res !== 32'h2) begin fails++; $display("FAIL midrst_after_res got=%h exp=00000002", res); end
    take_res();
  endtask

  task automatic test_chain_cin();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, lat);
    tests++; if (res !== 32'h0) begin fails++; $display("FAIL cin_res got=%h exp=0", res); end
    tests++; if ({flag_c, flag_z, flag_n, flag_v} !== 4'b1100) begin fails++;
      $display("FAIL cin_flags got=%b exp=1100", {flag_c, flag_z, flag_n, flag_v}); end
    take_res();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'h1, 32'h2, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++; if (res !== 32'h3 || res_valid !== 1'b1) begin fails++;
        $display("FAIL hold_res cyc=%0d got=%h/%b exp=00000003/1", i, res, res_valid); end
      tests++; if (op_ready !== 1'b0) begin fails++; $display("FAIL hold_ready cyc=%0d got=%b exp=0", i, op_ready); end
    end
    @(negedge clk);
    res_ready = 1'b1; op_valid = 1'b1; op_a = 32'h5; op_b = 32'h6; op_sub = 1'b0; op_cin = 1'b0;
    #1;
    tests++; if (op_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got=%b exp=1", op_ready); end
    @(posedge clk);
    #1;
    res_ready = 1'b0; op_valid = 1'b0; op_a = 32'hDEAD_BEEF;
    tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop got=%b exp=0", res_valid); end
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    tests++; if (lat !== 4) begin fails++; $display("FAIL b2b_latency got=%0d exp=4", lat); end
    tests++; if (res !== 32'hB) begin fails++; $display("FAIL b2b_res got=%h exp=0000000b", res); end
    take_res();
  endtask

  task automatic test_bytes1();
    int lat;
    @(negedge clk);
    op_a1 = 8'hFF; op_b1 = 8'h01; op_sub1 = 1'b0; op_cin1 = 1'b0; op_valid1 = 1'b1;
    @(posedge clk);
    #1 op_valid1 = 1'b0; op_a1 = 8'h00;
    lat = 0;
    while (!res_valid1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    tests++; if (lat !== 1) begin fails++; $display("FAIL b1_latency got=%0d exp=1", lat); end
    tests++; if (res1 !== 8'h00) begin fails++; $display("FAIL b1_res got=%h exp=00", res1); end
    tests++; if ({flag_c1, flag_z1, flag_n1, flag_v1} !== 4'b1100) begin fails++;
      $display("FAIL b1_flags got=%b exp=1100", {flag_c1, flag_z1, flag_n1, flag_v1}); end
    @(negedge clk);
    res_ready1 = 1'b1;
    @(posedge clk);
    #1 res_ready1 = 1'b0;
    tests++; if (res_valid1 !== 1'b0 || op_ready1 !== 1'b1) begin fails++;
      $display("FAIL b1_release got=%b/%b exp=0/1", res_valid1, op_ready1); end
  endtask

  initial begin
    op_valid = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0; op_cin = 1'b0; res_ready = 1'b0;
    op_valid1 = 1'b0; op_a1 = '0; op_b1 = '0; op_sub1 = 1'b0; op_cin1 = 1'b0; res_ready1 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_reset_mid_run();
    test_chain_cin();
    test_back_to_back();
    test_bytes1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
